// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock monitor on the free-running reference clock.
// Holds the core in reset until the PLL lock has held steady, re-arms the PLL on lock timeout.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             core_rst_n,
  output logic             locked_sync,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_lost_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int CYC_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int CYC_MAX   = (CYC_MAX_A > STABLE_CYCLES) ? CYC_MAX_A : STABLE_CYCLES;
  localparam int CYC_W     = $clog2(CYC_MAX + 1);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [CNT_W-1:0]       lost_q, lost_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   lock_next;

  // The FSM looks at the value entering the last sync stage, so a state change
  // lands on the same edge as the matching locked_sync change.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pll_locked};
    lock_next = sync_q[SYNC_STAGES-2];
    state_d   = state_q;
    cyc_d     = cyc_q + CYC_W'(1);
    lost_d    = lost_q;
    tmo_d     = tmo_q;

    case (state_q)
      ST_PLL_RST: begin
        if (cyc_q == CYC_W'(PLL_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_next) begin
          state_d = ST_STABLE;
        end else if (cyc_q == CYC_W'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_PLL_RST;
          if (tmo_q != '1) tmo_d = tmo_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_next) state_d = ST_WAIT_LOCK;
        else if (cyc_q == CYC_W'(STABLE_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_next) begin
          state_d = ST_WAIT_LOCK;
          if (lost_q != '1) lost_d = lost_q + CNT_W'(1);
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    if (state_d != state_q) cyc_d = '0;

    pll_rst_d    = (state_d == ST_PLL_RST);
    core_rst_n_d = (state_d == ST_RUN);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q      <= ST_PLL_RST;
      sync_q       <= '0;
      cyc_q        <= '0;
      lost_q       <= '0;
      tmo_q        <= '0;
      pll_rst_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cyc_q        <= cyc_d;
      lost_q       <= lost_d;
      tmo_q        <= tmo_d;
      pll_rst_q    <= pll_rst_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign core_rst_n    = core_rst_n_q;
  assign locked_sync   = sync_q[SYNC_STAGES-1];
  assign state         = state_q;
  assign lock_lost_cnt = lost_q;
  assign timeout_cnt   = tmo_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
// Expected values are hand-derived edge counts from each stimulus point.
module tb_pll_lock_supervisor;

  localparam int CNT_W = 2;

  logic             refclk;
  logic             rst_n;
  logic             pll_locked;
  logic             pll_rst;
  logic             core_rst_n;
  logic             locked_sync;
  logic [1:0]       state;
  logic [CNT_W-1:0] lock_lost_cnt;
  logic [CNT_W-1:0] timeout_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .core_rst_n   (core_rst_n),
    .locked_sync  (locked_sync),
    .state        (state),
    .lock_lost_cnt(lock_lost_cnt),
    .timeout_cnt  (timeout_cnt)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("  ok   %-24s = %0d", tag, got);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;

    // Reset held 3 edges with lock already high
    tick(3);
    check("rst.state", 32'(state), 0);
    check("rst.pll_rst", 32'(pll_rst), 1);
    check("rst.core_rst_n", 32'(core_rst_n), 0);
    check("rst.locked_sync", 32'(locked_sync), 0);
    check("rst.lost", 32'(lock_lost_cnt), 0);
    check("rst.tmo", 32'(timeout_cnt), 0);

    rst_n = 1'b1;
    tick(3);
    check("t1.pll_rst_e3", 32'(pll_rst), 1);
    check("t1.state_e3", 32'(state), 0);
    check("t1.lsync_e3", 32'(locked_sync), 1);
    tick(1);
    check("t1.pll_rst_e4", 32'(pll_rst), 0);
    check("t1.state_e4", 32'(state), 1);
    tick(1);
    check("t1.state_stable", 32'(state), 2);
    tick(7);
    check("t1.state_s7", 32'(state), 2);
    check("t1.core_s7", 32'(core_rst_n), 0);
    tick(1);
    check("t1.state_run", 32'(state), 3);
    check("t1.core_run", 32'(core_rst_n), 1);
    check("t1.lost", 32'(lock_lost_cnt), 0);
    check("t1.tmo", 32'(timeout_cnt), 0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(1);
    check("t3.state_e1", 32'(state), 3);
    check("t3.core_e1", 32'(core_rst_n), 1);
    tick(1);
    check("t3.lsync", 32'(locked_sync), 0);
    check("t3.core", 32'(core_rst_n), 0);
    check("t3.state", 32'(state), 1);
    check("t3.lost", 32'(lock_lost_cnt), 1);
    check("t3.tmo", 32'(timeout_cnt), 0);
    pll_locked = 1'b1;
    tick(1);
    check("t3.relock_e1", 32'(state), 1);
    tick(1);
    check("t3.relock_stable", 32'(state), 2);
    tick(7);
    check("t3.relock_s7", 32'(state), 2);
    tick(1);
    check("t3.relock_run", 32'(state), 3);
    check("t3.relock_core", 32'(core_rst_n), 1);

    // Second loss to get back into STABLE, then a one-cycle glitch at counter 5
    pll_locked = 1'b0;
    tick(2);
    check("t4.loss2_state", 32'(state), 1);
    check("t4.loss2_lost", 32'(lock_lost_cnt), 2);
    pll_locked = 1'b1;
    tick(2);
    check("t4.stable_entry", 32'(state), 2);
    tick(4);
    pll_locked = 1'b0;
    tick(1);
    check("t4.glitch_e5", 32'(state), 2);
    pll_locked = 1'b1;
    tick(1);
    check("t4.glitch_state", 32'(state), 1);
    check("t4.glitch_lsync", 32'(locked_sync), 0);
    check("t4.glitch_lost", 32'(lock_lost_cnt), 2);
    tick(1);
    check("t4.reenter", 32'(state), 2);
    tick(7);
    check("t4.reenter_s7", 32'(state), 2);
    tick(1);
    check("t4.run", 32'(state), 3);
    check("t4.lost_final", 32'(lock_lost_cnt), 2);

    // One-edge reset in RUN
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("t6.state", 32'(state), 0);
    check("t6.pll_rst", 32'(pll_rst), 1);
    check("t6.core", 32'(core_rst_n), 0);
    check("t6.lost", 32'(lock_lost_cnt), 0);
    check("t6.tmo", 32'(timeout_cnt), 0);
    check("t6.lsync", 32'(locked_sync), 0);

    // No lock at all: timeouts
    pll_locked = 1'b0;
    rst_n      = 1'b1;
    tick(4);
    check("t2.wait_entry", 32'(state), 1);
    check("t2.wait_pll_rst", 32'(pll_rst), 0);
    tick(19);
    check("t2.wait_19", 32'(state), 1);
    tick(1);
    check("t2.tmo1_state", 32'(state), 0);
    check("t2.tmo1_pll_rst", 32'(pll_rst), 1);
    check("t2.tmo1_cnt", 32'(timeout_cnt), 1);
    tick(3);
    check("t2.rearm_e3", 32'(pll_rst), 1);
    tick(1);
    check("t2.rearm_e4", 32'(state), 1);

    // Lock arriving on the very edge the timeout would fire
    tick(18);
    pll_locked = 1'b1;
    tick(1);
    check("t5.e19_state", 32'(state), 1);
    tick(1);
    check("t5.state", 32'(state), 2);
    check("t5.tmo", 32'(timeout_cnt), 1);
    check("t5.lsync", 32'(locked_sync), 1);

    // Drop in STABLE is not a loss; then run timeouts into saturation
    pll_locked = 1'b0;
    tick(1);
    check("t2b.stable_hold", 32'(state), 2);
    tick(1);
    check("t2b.back_wait", 32'(state), 1);
    check("t2b.lost", 32'(lock_lost_cnt), 0);
    tick(19);
    check("t2b.wait_19", 32'(state), 1);
    tick(1);
    check("t2b.tmo2", 32'(timeout_cnt), 2);
    tick(4);
    check("t2b.rearm2", 32'(state), 1);
    tick(20);
    check("t2b.tmo3", 32'(timeout_cnt), 3);
    check("t2b.tmo3_state", 32'(state), 0);
    tick(4);
    tick(20);
    check("t2b.tmo_sat", 32'(timeout_cnt), 3);
    check("t2b.tmo_sat_state", 32'(state), 0);
    check("t2b.tmo_sat_pll_rst", 32'(pll_rst), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
